spi_slave_regfile: RTL and testbench

//  SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, 8-bit frames) with a 16 x 8 register file.
//  It is the responder end of the AHB SPI master link and stands in for an external

---
 rtl/spi_slave_regfile.sv | 145 ++++++++++++++
 tb/tb_spi_slave_regfile.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave (MSB first, 8-bit frames) fronting a 16 x 8 register bank.
// Every SPI pin is oversampled on HCLK, so SCLK is treated as data and never used as a clock.
module spi_slave_regfile #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       SCLK,
  input  logic       CS_N,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [7:0] STATUS_IN,
  output logic       WR_EN,
  output logic [3:0] WR_ADDR,
  output logic [7:0] WR_DATA
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] csSync_q;
  logic [SYNC_STAGES-1:0] mosiSync_q;
  logic                   sclkPrev_q;
  logic                   csPrev_q;

  logic sclkS, csS, mosiS;
  logic sclkRise, sclkFall, csFall;

  state_e     state_q;
  logic [2:0] bitCnt_q;
  logic [6:0] rxShift_q;
  logic [7:0] txShift_q;
  logic       isWrite_q;
  logic [3:0] addr_q;
  logic [7:0] regFile_q [16];
  logic       misoOe_q;
  logic       wrEn_q;
  logic [3:0] wrAddr_q;
  logic [7:0] wrData_q;

  logic [7:0] rxByte_d;
  logic [3:0] addr_d;

  // CS_N resets to deselected so a reset never looks like a select edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sclkSync_q <= '0;
      csSync_q   <= '1;
      mosiSync_q <= '0;
      sclkPrev_q <= 1'b0;
      csPrev_q   <= 1'b1;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], SCLK};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], CS_N};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], MOSI};
      sclkPrev_q <= sclkS;
      csPrev_q   <= csS;
    end
  end

  assign sclkS    = sclkSync_q[SYNC_STAGES-1];
  assign csS      = csSync_q[SYNC_STAGES-1];
  assign mosiS    = mosiSync_q[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev_q;
  assign sclkFall = ~sclkS & sclkPrev_q;
  assign csFall   = ~csS & csPrev_q;

  assign rxByte_d = {rxShift_q, mosiS};
  assign addr_d   = addr_q + 4'd1;

  function automatic logic [7:0] readReg(input logic [3:0] a);
    if (a == 4'd0)      return ID_VALUE;
    else if (a == 4'd1) return STATUS_IN;
    else                return regFile_q[a];
  endfunction

  // Deselect has priority over everything, including a byte completing in the same cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      rxShift_q <= '0;
      txShift_q <= '0;
      isWrite_q <= 1'b0;
      addr_q    <= '0;
      misoOe_q  <= 1'b0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      for (int i = 0; i < 16; i++) regFile_q[i] <= '0;
    end else begin
      wrEn_q   <= 1'b0;
      misoOe_q <= ~csS;
      if (csS) begin
        state_q   <= IDLE;
        bitCnt_q  <= '0;
        txShift_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            txShift_q <= '0;
            bitCnt_q  <= '0;
            if (csFall) state_q <= CMD;
          end
          CMD, DATA: begin
            if (sclkRise) begin
              rxShift_q <= rxByte_d[6:0];
              bitCnt_q  <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                if (state_q == CMD) begin
                  state_q   <= DATA;
                  isWrite_q <= rxByte_d[7];
                  addr_q    <= rxByte_d[3:0];
                  txShift_q <= rxByte_d[7] ? 8'h00 : readReg(rxByte_d[3:0]);
                end else begin
                  if (isWrite_q && addr_q >= 4'd2) begin
                    regFile_q[addr_q] <= rxByte_d;
                    wrEn_q            <= 1'b1;
                    wrAddr_q          <= addr_q;
                    wrData_q          <= rxByte_d;
                  end
                  addr_q    <= addr_d;
                  txShift_q <= isWrite_q ? 8'h00 : readReg(addr_d);
                end
              end
            end else if (sclkFall && bitCnt_q != 3'd0) begin
              // At a byte boundary the freshly loaded byte must present its MSB first.
              txShift_q <= {txShift_q[6:0], 1'b0};
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign MISO    = txShift_q[7] & misoOe_q;
  assign MISO_OE = misoOe_q;
  assign WR_EN   = wrEn_q;
  assign WR_ADDR = wrAddr_q;
  assign WR_DATA = wrData_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: a bit-banged SPI master, a register-map
// reference model, and two monitors (MISO bytes, write pulses) draining expectation queues.
module tb_spi_slave_regfile;

  localparam int HALF = 6;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       SCLK;
  logic       CS_N;
  logic       MOSI;
  logic       MISO;
  logic       MISO_OE;
  logic [7:0] STATUS_IN;
  logic       WR_EN;
  logic [3:0] WR_ADDR;
  logic [7:0] WR_DATA;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  model [16];
  logic [7:0]  expMisoQ [$];
  logic [11:0] expWrQ [$];

  int         mBits = 0;
  logic [7:0] mByte = 8'h00;

  always #5 HCLK = ~HCLK;

  spi_slave_regfile #(.SYNC_STAGES(2), .ID_VALUE(8'hA5)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .STATUS_IN(STATUS_IN),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitHclk(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  function automatic logic [7:0] modelRead(input logic [3:0] a);
    if (a == 4'd0)      return 8'hA5;
    else if (a == 4'd1) return STATUS_IN;
    else                return model[a];
  endfunction

  task automatic shiftBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = b[i];
      waitHclk(HALF);
      SCLK = 1'b1;
      waitHclk(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic selectSlave();
    CS_N = 1'b0;
    waitHclk(HALF);
    checkOutput("miso_oe_selected", 32'(MISO_OE), 32'd1);
  endtask

  task automatic deselectSlave();
    waitHclk(HALF);
    CS_N = 1'b1;
    waitHclk(HALF);
    checkOutput("miso_oe_deselected", 32'(MISO_OE), 32'd0);
    checkOutput("miso_deselected", 32'(MISO), 32'd0);
  endtask

  // Expectations come from the register map rules; data bytes are taken LSB-byte first.
  task automatic applyStimulus(input logic [7:0] cmd, input int n, input logic [127:0] data);
    logic [3:0] a;
    logic [7:0] b;
    expMisoQ.push_back(8'h00);
    a = cmd[3:0];
    for (int k = 0; k < n; k++) begin
      b = data[8*k +: 8];
      if (cmd[7]) begin
        expMisoQ.push_back(8'h00);
        if (a >= 4'd2) begin
          model[a] = b;
          expWrQ.push_back({a, b});
        end
      end else begin
        expMisoQ.push_back(modelRead(a));
      end
      a = a + 4'd1;
    end
    selectSlave();
    shiftBits(cmd, 8);
    for (int k = 0; k < n; k++) shiftBits(data[8*k +: 8], 8);
    deselectSlave();
  endtask

  // MISO monitor: assembles whole bytes on the master's sampling edge.
  always @(posedge SCLK or posedge CS_N or posedge HRESET) begin
    if (CS_N || HRESET) begin
      mBits = 0;
    end else begin
      mByte = {mByte[6:0], MISO};
      mBits++;
      if (mBits == 8) begin
        mBits = 0;
        if (expMisoQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL miso_unexpected: got 0x%0h, expected no byte", mByte);
        end else begin
          checkOutput("miso_byte", 32'(mByte), 32'(expMisoQ.pop_front()));
        end
      end
    end
  end

  // Write monitor: every WR_EN cycle must match the next expected commit.
  always @(negedge HCLK) begin
    logic [11:0] e;
    if (HRESET !== 1'b1 && WR_EN === 1'b1) begin
      if (expWrQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", WR_ADDR, WR_DATA);
      end else begin
        e = expWrQ.pop_front();
        checkOutput("wr_addr", 32'(WR_ADDR), 32'(e[11:8]));
        checkOutput("wr_data", 32'(WR_DATA), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #5_000_000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] cmd;
    logic [127:0] data;
    int n;

    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    HRESET = 1'b1; CS_N = 1'b1; SCLK = 1'b0; MOSI = 1'b0; STATUS_IN = 8'h00;
    waitHclk(5);
    checkOutput("rst_miso", 32'(MISO), 32'd0);
    checkOutput("rst_miso_oe", 32'(MISO_OE), 32'd0);
    checkOutput("rst_wr_en", 32'(WR_EN), 32'd0);
    checkOutput("rst_wr_addr", 32'(WR_ADDR), 32'd0);
    checkOutput("rst_wr_data", 32'(WR_DATA), 32'd0);
    HRESET = 1'b0;
    waitHclk(5);

    $display("[TB] directed write/read/ID/status/burst");
    applyStimulus(8'h85, 1, 128'h3C);
    applyStimulus(8'h05, 1, 128'h00);
    applyStimulus(8'h80, 1, 128'hFF);
    applyStimulus(8'h00, 1, 128'h00);
    STATUS_IN = 8'h5A;
    applyStimulus(8'h01, 1, 128'h00);
    applyStimulus(8'h8E, 4, 128'h44332211);
    applyStimulus(8'h0E, 2, 128'h0000);

    $display("[TB] abort mid data byte");
    applyStimulus(8'h87, 1, 128'h6B);
    expMisoQ.push_back(8'h00);
    selectSlave();
    shiftBits(8'h87, 8);
    shiftBits(8'h99, 4);
    deselectSlave();
    applyStimulus(8'h07, 1, 128'h00);

    $display("[TB] deselect coinciding with 8th rising edge");
    applyStimulus(8'h88, 1, 128'h12);
    expMisoQ.push_back(8'h00);
    selectSlave();
    shiftBits(8'h88, 8);
    shiftBits(8'hC3, 7);
    MOSI = 1'b1;
    waitHclk(HALF);
    CS_N = 1'b1;
    SCLK = 1'b1;
    waitHclk(HALF);
    SCLK = 1'b0;
    waitHclk(2 * HALF);
    applyStimulus(8'h08, 1, 128'h00);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 20; t++) begin
      cmd       = 8'($urandom);
      n         = $urandom_range(1, 4);
      data      = {$urandom, $urandom, $urandom, $urandom};
      STATUS_IN = 8'($urandom);
      applyStimulus(cmd, n, data);
    end

    $display("[TB] reset during a read byte");
    applyStimulus(8'h89, 1, 128'hFF);
    expMisoQ.push_back(8'h00);
    selectSlave();
    shiftBits(8'h09, 8);
    shiftBits(8'h00, 3);
    checkOutput("miso_before_reset", 32'(MISO), 32'd1);
    HRESET = 1'b1;
    #1;
    checkOutput("midrst_miso", 32'(MISO), 32'd0);
    checkOutput("midrst_miso_oe", 32'(MISO_OE), 32'd0);
    checkOutput("midrst_wr_en", 32'(WR_EN), 32'd0);
    CS_N = 1'b1;
    SCLK = 1'b0;
    for (int i = 2; i < 16; i++) model[i] = 8'h00;
    waitHclk(4);
    HRESET = 1'b0;
    waitHclk(4);
    applyStimulus(8'h02, 14, 128'h0);

    waitHclk(20);
    checkOutput("miso_queue_drained", 32'(expMisoQ.size()), 32'd0);
    checkOutput("wr_queue_drained", 32'(expWrQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
